// File: rtl/tmr_scrub_register_if.sv
// Bus bundle for tmr_scrub_register: write port, fault-injection masks,
// counter clear, and the voted word plus error status.
interface tmr_scrub_register_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
) ();
  logic                 en;
  logic [WIDTH-1:0]     d;
  logic [WIDTH-1:0]     seu_inj_a;
  logic [WIDTH-1:0]     seu_inj_b;
  logic [WIDTH-1:0]     seu_inj_c;
  logic                 err_cnt_clr;
  logic [WIDTH-1:0]     q;
  logic [2:0]           err_chan;
  logic                 err_sticky;
  logic [CNT_WIDTH-1:0] err_cnt;

  modport master (
    output en, d, seu_inj_a, seu_inj_b, seu_inj_c, err_cnt_clr,
    input  q, err_chan, err_sticky, err_cnt
  );

  modport slave (
    input  en, d, seu_inj_a, seu_inj_b, seu_inj_c, err_cnt_clr,
    output q, err_chan, err_sticky, err_cnt
  );
endinterface

// File: rtl/tmr_scrub_register.sv
// Triplicated storage word with bitwise majority vote, optional scrubbing
// of the copies from the voted value, and saturating mismatch accounting.
module tmr_scrub_register #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      CNT_WIDTH   = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SCRUB       = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  tmr_scrub_register_if.slave bus
);

  logic [WIDTH-1:0]     copy_a_q, copy_b_q, copy_c_q;
  logic [WIDTH-1:0]     copy_a_d, copy_b_d, copy_c_d;
  logic [WIDTH-1:0]     base_a, base_b, base_c;
  logic [WIDTH-1:0]     voted;
  logic [2:0]           mismatch;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 err_sticky_q, err_sticky_d;

  // Per-bit 2-of-3 majority and per-copy disagreement with the vote
  always_comb begin
    voted    = (copy_a_q & copy_b_q) | (copy_a_q & copy_c_q) | (copy_b_q & copy_c_q);
    mismatch = {|(copy_c_q ^ voted), |(copy_b_q ^ voted), |(copy_a_q ^ voted)};
  end

  // Copy next-state: write data, else voted word (scrub) or own value
  always_comb begin
    if (bus.en) begin
      base_a = bus.d;
      base_b = bus.d;
      base_c = bus.d;
    end else if (SCRUB) begin
      base_a = voted;
      base_b = voted;
      base_c = voted;
    end else begin
      base_a = copy_a_q;
      base_b = copy_b_q;
      base_c = copy_c_q;
    end
    // Injection applies on top of a write too, so the write itself can be upset
    copy_a_d = base_a ^ bus.seu_inj_a;
    copy_b_d = base_b ^ bus.seu_inj_b;
    copy_c_d = base_c ^ bus.seu_inj_c;
  end

  // Error accounting: clear beats increment, counter saturates at all ones
  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (bus.err_cnt_clr) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (|mismatch) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers; reset overrides writes, clears and injection
  always_ff @(posedge clk) begin
    if (rst) begin
      copy_a_q     <= RESET_VALUE;
      copy_b_q     <= RESET_VALUE;
      copy_c_q     <= RESET_VALUE;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      copy_a_q     <= copy_a_d;
      copy_b_q     <= copy_b_d;
      copy_c_q     <= copy_c_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.q          = voted;
  assign bus.err_chan   = mismatch;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_tmr_scrub_register.sv
// Scoreboard bench for tmr_scrub_register: three instances (scrubbing,
// non-scrubbing, 2-bit counter) driven with directed vectors.
module tb_tmr_scrub_register;

  logic clk;
  logic rst;
  int unsigned cyc;
  int checks;
  int errors;

  typedef struct {
    int unsigned due;
    int unsigned dut;
    string       name;
    logic [7:0]  q;
    logic [2:0]  chan;
    logic [7:0]  cnt;
    logic        sticky;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  tmr_scrub_register_if #(.WIDTH(8), .CNT_WIDTH(8)) if_s1 ();
  tmr_scrub_register_if #(.WIDTH(8), .CNT_WIDTH(8)) if_s0 ();
  tmr_scrub_register_if #(.WIDTH(8), .CNT_WIDTH(2)) if_sat ();

  tmr_scrub_register #(.WIDTH(8), .CNT_WIDTH(8), .RESET_VALUE(8'h3C), .SCRUB(1'b1)) u_s1 (
    .clk(clk), .rst(rst), .bus(if_s1)
  );
  tmr_scrub_register #(.WIDTH(8), .CNT_WIDTH(8), .RESET_VALUE(8'h00), .SCRUB(1'b0)) u_s0 (
    .clk(clk), .rst(rst), .bus(if_s0)
  );
  tmr_scrub_register #(.WIDTH(8), .CNT_WIDTH(2), .RESET_VALUE(8'h00), .SCRUB(1'b0)) u_sat (
    .clk(clk), .rst(rst), .bus(if_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle_all();
    if_s1.en = 1'b0;  if_s1.d = '0;  if_s1.err_cnt_clr = 1'b0;
    if_s1.seu_inj_a = '0;  if_s1.seu_inj_b = '0;  if_s1.seu_inj_c = '0;
    if_s0.en = 1'b0;  if_s0.d = '0;  if_s0.err_cnt_clr = 1'b0;
    if_s0.seu_inj_a = '0;  if_s0.seu_inj_b = '0;  if_s0.seu_inj_c = '0;
    if_sat.en = 1'b0; if_sat.d = '0; if_sat.err_cnt_clr = 1'b0;
    if_sat.seu_inj_a = '0; if_sat.seu_inj_b = '0; if_sat.seu_inj_c = '0;
  endtask

  // Advance past the next edge and return all non-reset inputs to idle
  task automatic step();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  // Expected outputs after the coming edge
  task automatic expect_next(input int unsigned dut, input string name, input logic [7:0] q,
                             input logic [2:0] chan, input logic [7:0] cnt, input logic sticky);
    exp_t e;
    e.due = cyc + 1; e.dut = dut; e.name = name;
    e.q = q; e.chan = chan; e.cnt = cnt; e.sticky = sticky;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input string field, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %02h expected %02h (cycle %0d)", name, field, act, exp, cyc);
    end
  endtask

  // Monitor: pop every expectation due at this cycle and compare
  always @(negedge clk) begin
    logic [7:0] aq, acnt;
    logic [2:0] achan;
    logic       asticky;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.due != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: sample missed, due %0d at cycle %0d", mon_e.name, mon_e.due, cyc);
      end else begin
        case (mon_e.dut)
          0: begin aq = if_s1.q; achan = if_s1.err_chan; acnt = if_s1.err_cnt; asticky = if_s1.err_sticky; end
          1: begin aq = if_s0.q; achan = if_s0.err_chan; acnt = if_s0.err_cnt; asticky = if_s0.err_sticky; end
          default: begin
            aq = if_sat.q; achan = if_sat.err_chan;
            acnt = {6'b0, if_sat.err_cnt}; asticky = if_sat.err_sticky;
          end
        endcase
        chk(mon_e.name, "q",          aq,               mon_e.q);
        chk(mon_e.name, "err_chan",   {5'b0, achan},    {5'b0, mon_e.chan});
        chk(mon_e.name, "err_cnt",    acnt,             mon_e.cnt);
        chk(mon_e.name, "err_sticky", {7'b0, asticky},  {7'b0, mon_e.sticky});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_all();

    // Reset held for two edges
    step();
    expect_next(0, "rst_s1", 8'h3C, 3'b000, 8'd0, 1'b0);
    expect_next(1, "rst_s0", 8'h00, 3'b000, 8'd0, 1'b0);
    expect_next(2, "rst_sat", 8'h00, 3'b000, 8'd0, 1'b0);
    step(); rst = 1'b0;
    expect_next(0, "post_rst_s1", 8'h3C, 3'b000, 8'd0, 1'b0);

    // SCRUB=1: write, single upset in B, scrubbed next cycle
    step(); if_s1.en = 1'b1; if_s1.d = 8'hA5;
    expect_next(0, "s1_write", 8'hA5, 3'b000, 8'd0, 1'b0);
    step(); if_s1.seu_inj_b = 8'h01;
    expect_next(0, "s1_inj_b", 8'hA5, 3'b010, 8'd0, 1'b0);
    step();
    expect_next(0, "s1_scrubbed", 8'hA5, 3'b000, 8'd1, 1'b1);
    step();
    expect_next(0, "s1_hold", 8'hA5, 3'b000, 8'd1, 1'b1);

    // Different copies hit in different bits
    step(); if_s1.seu_inj_a = 8'h01; if_s1.seu_inj_c = 8'h80;
    expect_next(0, "s1_multi", 8'hA5, 3'b101, 8'd1, 1'b1);
    step();
    expect_next(0, "s1_multi_fix", 8'hA5, 3'b000, 8'd2, 1'b1);

    // Same bit in two copies: vote goes wrong, scrub propagates it
    step(); if_s1.seu_inj_a = 8'h01; if_s1.seu_inj_b = 8'h01;
    expect_next(0, "s1_double", 8'hA4, 3'b100, 8'd2, 1'b1);
    step();
    expect_next(0, "s1_double_scrub", 8'hA4, 3'b000, 8'd3, 1'b1);
    step();
    expect_next(0, "s1_double_hold", 8'hA4, 3'b000, 8'd3, 1'b1);

    // Write upset on the same edge
    step(); if_s1.en = 1'b1; if_s1.d = 8'h0F; if_s1.seu_inj_c = 8'h10;
    expect_next(0, "s1_write_inj", 8'h0F, 3'b100, 8'd3, 1'b1);
    step();
    expect_next(0, "s1_write_inj_fix", 8'h0F, 3'b000, 8'd4, 1'b1);

    // Clear, then clear beating a simultaneous increment
    step(); if_s1.err_cnt_clr = 1'b1;
    expect_next(0, "s1_clr", 8'h0F, 3'b000, 8'd0, 1'b0);
    step(); if_s1.seu_inj_a = 8'h01;
    expect_next(0, "s1_inj_a", 8'h0F, 3'b001, 8'd0, 1'b0);
    step(); if_s1.err_cnt_clr = 1'b1;
    expect_next(0, "s1_clr_wins", 8'h0F, 3'b000, 8'd0, 1'b0);

    // SCRUB=0: upset persists and counts every cycle until rewritten
    step(); if_s0.en = 1'b1; if_s0.d = 8'hA5;
    expect_next(1, "s0_write", 8'hA5, 3'b000, 8'd0, 1'b0);
    step(); if_s0.seu_inj_b = 8'h01;
    expect_next(1, "s0_inj_b", 8'hA5, 3'b010, 8'd0, 1'b0);
    step();
    expect_next(1, "s0_cnt1", 8'hA5, 3'b010, 8'd1, 1'b1);
    step();
    expect_next(1, "s0_cnt2", 8'hA5, 3'b010, 8'd2, 1'b1);
    step();
    expect_next(1, "s0_cnt3", 8'hA5, 3'b010, 8'd3, 1'b1);
    step(); if_s0.en = 1'b1; if_s0.d = 8'h5A;
    expect_next(1, "s0_rewrite", 8'h5A, 3'b000, 8'd4, 1'b1);
    step();
    expect_next(1, "s0_stopped", 8'h5A, 3'b000, 8'd4, 1'b1);
    step(); if_s0.seu_inj_a = 8'h01; if_s0.seu_inj_c = 8'h80;
    expect_next(1, "s0_multi", 8'h5A, 3'b101, 8'd4, 1'b1);
    step();
    expect_next(1, "s0_multi_hold", 8'h5A, 3'b101, 8'd5, 1'b1);
    step(); if_s0.en = 1'b1; if_s0.d = 8'h00;
    expect_next(1, "s0_multi_rewrite", 8'h00, 3'b000, 8'd6, 1'b1);

    // 2-bit counter saturation and clear during a persisting mismatch
    step(); if_sat.seu_inj_a = 8'h01;
    expect_next(2, "sat_inj", 8'h00, 3'b001, 8'd0, 1'b0);
    step(); expect_next(2, "sat_1", 8'h00, 3'b001, 8'd1, 1'b1);
    step(); expect_next(2, "sat_2", 8'h00, 3'b001, 8'd2, 1'b1);
    step(); expect_next(2, "sat_3", 8'h00, 3'b001, 8'd3, 1'b1);
    step(); expect_next(2, "sat_hold4", 8'h00, 3'b001, 8'd3, 1'b1);
    step(); expect_next(2, "sat_hold5", 8'h00, 3'b001, 8'd3, 1'b1);
    step(); if_sat.err_cnt_clr = 1'b1;
    expect_next(2, "sat_clr", 8'h00, 3'b001, 8'd0, 1'b0);
    step(); expect_next(2, "sat_resume", 8'h00, 3'b001, 8'd1, 1'b1);

    // Reset overrides write, injection and pending errors
    step(); rst = 1'b1;
    if_s1.en = 1'b1; if_s1.d = 8'hFF; if_s1.seu_inj_a = 8'hFF;
    if_s0.seu_inj_b = 8'hFF;
    if_sat.en = 1'b1; if_sat.d = 8'hFF; if_sat.seu_inj_c = 8'h0F;
    expect_next(0, "rst_prio_s1", 8'h3C, 3'b000, 8'd0, 1'b0);
    expect_next(1, "rst_prio_s0", 8'h00, 3'b000, 8'd0, 1'b0);
    expect_next(2, "rst_prio_sat", 8'h00, 3'b000, 8'd0, 1'b0);
    step(); rst = 1'b0;
    expect_next(0, "rst_after_s1", 8'h3C, 3'b000, 8'd0, 1'b0);
    expect_next(2, "rst_after_sat", 8'h00, 3'b000, 8'd0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmr_scrub_register.md
Name: tmr_scrub_register

Overview:
- Parametrised triplicated storage register with per-bit majority voting, optional continuous scrubbing and error accounting.
- This is the sequential, parametrised successor to the single-bit fanout/majority-voter combinational cells.
- It sits wherever a configuration or state word must survive single-event upsets.
- It exposes per-copy mismatch status, a saturating upset counter and a fault-injection port for verification.

Parameters:
- WIDTH, 8, data width of each copy and of the voted output.
- CNT_WIDTH, 8, width of the saturating error counter.
- RESET_VALUE, 0, value loaded into all three copies on reset (WIDTH bits).
- SCRUB, 1. When 1, idle cycles reload every copy from the voted value. When 0, copies hold their own value.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  write enable; loads d into all three copies.
- d  input  WIDTH  write data.
- seu_inj_a  input  WIDTH  XOR mask applied to copy A at the edge (verification only; tie 0 in silicon).
- seu_inj_b  input  WIDTH  XOR mask for copy B.
- seu_inj_c  input  WIDTH  XOR mask for copy C.
- err_cnt_clr  input  1  synchronous clear of err_cnt and err_sticky.
- q  output  WIDTH  bitwise majority of copies A/B/C (combinational from the registers).
- err_chan  output  3  {C,B,A} per-copy mismatch vs q (combinational).
- err_sticky  output  1  set on any mismatch; cleared only by rst or err_cnt_clr.
- err_cnt  output  CNT_WIDTH  number of clock edges sampled with any mismatch; saturates.

Behaviour:
- Reset (rst=1 at edge):
  - copies A/B/C <= RESET_VALUE, err_cnt <= 0, err_sticky <= 0.
  - Injection masks are ignored.
  - Outputs after that edge: q=RESET_VALUE, err_chan=0.
  - rst has priority over en, err_cnt_clr and injection.
- Copy next-state per copy X, when rst=0:
  - base = d if en=1; else q if SCRUB=1; else X.
  - X <= base XOR seu_inj_X.
- Voter: q[i] = (A[i]&B[i]) | (A[i]&C[i]) | (B[i]&C[i]), for each bit independently.
- Mismatch:
  - err_chan[A] = |(A XOR q); likewise for B and C.
  - Different copies wrong in different bits: still corrected. q stays correct and several err_chan bits are set.
  - Two copies wrong in the same bit: q takes the wrong value and the lone correct copy is flagged. This is accepted behaviour, not detected as uncorrectable.
- Latency:
  - Write data appears on q 1 cycle after en.
  - An injected upset is visible on err_chan 1 cycle after the injection edge.
  - With SCRUB=1, the upset is corrected 1 cycle later (err_chan returns to 0 two cycles after the injection edge), provided no new injection occurs.
  - With SCRUB=0, the upset persists until the next en write.
- Counter, evaluated at each edge with rst=0:
  - If err_cnt_clr=1: err_cnt <= 0 and err_sticky <= 0. Clear wins over a simultaneous increment.
  - Else if err_chan != 0: err_cnt <= err_cnt+1 unless already all ones (stays at 2^CNT_WIDTH-1); err_sticky <= 1.
  - The counter counts cycles with a mismatch, not distinct upsets.
- Simultaneous en and injection: the copy stores d XOR mask, so the write itself can be upset.
- No handshake. en is accepted on every cycle it is high.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0, with RESET_VALUE=0x3C -> q=0x3C, err_chan=000, err_cnt=0, err_sticky=0.
- Write + SCRUB=1 scrub: en=1 d=0xA5; next cycle en=0, seu_inj_b=0x01 for one cycle.
  - Next cycle: q=0xA5, err_chan=010.
  - Following cycle: err_chan=000, err_cnt=1, err_sticky=1.
- SCRUB=0 persistence: same injection -> err_chan=010 held and err_cnt increments each cycle (1,2,3). Then en=1 d=0x5A -> q=0x5A, err_chan=000, counting stops.
- Multi-copy, different bits: q=0xA5, inject a=0x01 and c=0x80 on the same edge -> q=0xA5, err_chan=101, err_cnt +1 per mismatched cycle.
- Same-bit double fault: inject a=0x01 and b=0x01 -> q=0xA4, err_chan=100. With SCRUB=1, all copies become 0xA4 next cycle and err_chan=000.
- Saturation/clear priority: CNT_WIDTH=2, SCRUB=0, hold a mismatch for 5 cycles -> err_cnt=3 (saturated). Assert err_cnt_clr while the mismatch persists -> err_cnt=0, err_sticky=0 after that edge, and counting resumes the next cycle.
